// File: rtl/gate_array_pkg.sv
// Shared mode codes and gate evaluation helpers for the filtered gate array.
package gate_array_pkg;

  localparam logic [2:0] MODE_NOR  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_AND  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam logic [2:0] MODE_ZERO = 3'd6;
  localparam logic [2:0] MODE_ONE  = 3'd7;

  // Only the low 'width' bits of vec take part, so AND/NAND ignore padding.
  function automatic logic eval_gate(input logic [2:0] mode, input logic [7:0] vec,
                                     input int width);
    logic any_one;
    logic all_one;
    logic parity;
    logic res;
    any_one = 1'b0;
    all_one = 1'b1;
    parity  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < width) begin
        any_one = any_one | vec[i];
        all_one = all_one & vec[i];
        parity  = parity ^ vec[i];
      end
    end
    case (mode)
      MODE_NOR:  res = ~any_one;
      MODE_OR:   res = any_one;
      MODE_NAND: res = ~all_one;
      MODE_AND:  res = all_one;
      MODE_XOR:  res = parity;
      MODE_XNOR: res = ~parity;
      MODE_ZERO: res = 1'b0;
      default:   res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic reset_y(input logic [2:0] mode);
    return eval_gate(mode, 8'h00, 8);
  endfunction

endpackage

// File: rtl/gate_filter_channel.sv
// One gate channel: runtime mode, glitch filter counter and registered output.
module gate_filter_channel
  import gate_array_pkg::*;
#(
  parameter int         INPUTS       = 3,
  parameter int         FILTER_W     = 4,
  parameter logic [2:0] DEFAULT_MODE = 3'd0,
  parameter int         DEFAULT_FILT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INPUTS-1:0]   in_slice,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_mode,
  input  logic [FILTER_W-1:0] cfg_filt,
  output logic                y,
  output logic                y_chg
);

  logic [2:0]          mode_q, mode_d;
  logic [FILTER_W-1:0] filt_q, filt_d;
  logic [FILTER_W-1:0] cnt_q, cnt_d;
  logic                y_q, y_d;
  logic                y_chg_q, y_chg_d;
  logic [7:0]          vec;
  logic                f;

  always_comb begin
    vec = '0;
    vec[INPUTS-1:0] = in_slice;
    f = eval_gate(mode_q, vec, INPUTS);
  end

  // A config write owns the edge: counter restarts and y holds.
  always_comb begin
    mode_d  = mode_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    y_chg_d = 1'b0;
    if (cfg_we) begin
      mode_d = cfg_mode;
      filt_d = cfg_filt;
      cnt_d  = '0;
    end else if (f == y_q) begin
      cnt_d = '0;
    end else if (cnt_q == filt_q) begin
      y_d     = f;
      cnt_d   = '0;
      y_chg_d = 1'b1;
    end else begin
      cnt_d = cnt_q + FILTER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= DEFAULT_MODE;
      filt_q  <= FILTER_W'(DEFAULT_FILT);
      cnt_q   <= '0;
      y_q     <= reset_y(DEFAULT_MODE);
      y_chg_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      y_chg_q <= y_chg_d;
    end
  end

  assign y     = y_q;
  assign y_chg = y_chg_q;

endmodule

// File: rtl/param_gate_array_filtered.sv
// Array of CHANNELS configurable gates with a shared input register and config decode.
module param_gate_array_filtered
  import gate_array_pkg::*;
#(
  parameter int         CHANNELS     = 3,
  parameter int         INPUTS       = 3,
  parameter int         FILTER_W     = 4,
  parameter logic [2:0] DEFAULT_MODE = 3'd0,
  parameter int         DEFAULT_FILT = 0,
  localparam int        CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*INPUTS-1:0]   in_bus,
  input  logic                         cfg_wr,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [2:0]                   cfg_mode,
  input  logic [FILTER_W-1:0]          cfg_filt,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          y_chg,
  output logic                         cfg_err
);

  logic [CHANNELS*INPUTS-1:0] in_q, in_q_d;
  logic                       cfg_err_q, cfg_err_d;
  logic [CHANNELS-1:0]        ch_we;

  always_comb begin
    in_q_d    = in_bus;
    cfg_err_d = cfg_wr && (32'(cfg_ch) >= 32'(CHANNELS));
    ch_we     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cfg_wr && (cfg_ch == CH_W'(c))) ch_we[c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      in_q      <= in_q_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gate_filter_channel #(
      .INPUTS      (INPUTS),
      .FILTER_W    (FILTER_W),
      .DEFAULT_MODE(DEFAULT_MODE),
      .DEFAULT_FILT(DEFAULT_FILT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .in_slice(in_q[c*INPUTS +: INPUTS]),
      .cfg_we  (ch_we[c]),
      .cfg_mode(cfg_mode),
      .cfg_filt(cfg_filt),
      .y       (y[c]),
      .y_chg   (y_chg[c])
    );
  end

endmodule
